// File: rtl/packet_scheduler.sv
// packet_scheduler: round-robin HDMI data-island packet slot arbiter; PACKET_SCHEDULER_STATS_EN adds sent/null counters
module packet_scheduler #(
  parameter int NUM_SRC = 4,
  localparam int GW = $clog2(NUM_SRC)
) (
  input  logic                              clk_pixel,
  input  logic                              reset,
  input  logic                              data_island_period,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC-1:0][23:0]          src_header,
  input  logic [NUM_SRC-1:0][3:0][55:0]     src_sub,
  output logic [NUM_SRC-1:0]                src_ack,
  output logic [23:0]                       header,
  output logic [3:0][55:0]                  sub,
  output logic [4:0]                        slot_counter,
  output logic [GW-1:0]                     grant,
  output logic                              grant_valid
`ifdef PACKET_SCHEDULER_STATS_EN
  ,
  output logic [15:0]                       sent_count,
  output logic [15:0]                       null_count
`endif
);
  logic last, load, ack_ev, win_valid;
  logic [GW-1:0] ptr, ptr_eff, win, idx;
  logic [NUM_SRC-1:0] cand;
  always_comb begin
    last = data_island_period && slot_counter == 5'd31;
    load = !data_island_period || last;
    ack_ev = last && grant_valid;
    src_ack = ack_ev ? NUM_SRC'(1) << grant : '0;
    cand = src_valid & ~src_ack;
    ptr_eff = ack_ev ? grant : ptr;
  end
  // scan from ptr_eff+NUM_SRC down to ptr_eff+1 so the nearest candidate is written last
  always_comb begin
    win_valid = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = GW'((int'(ptr_eff) + k) % NUM_SRC);
      if (cand[idx]) begin
        win_valid = 1'b1;
        win = idx;
      end
    end
  end
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      slot_counter <= '0;
      header <= '0;
      sub <= '0;
      grant <= '0;
      grant_valid <= 1'b0;
      ptr <= GW'(NUM_SRC - 1);
    end else begin
      if (data_island_period) slot_counter <= slot_counter + 5'd1;
      ptr <= ptr_eff;
      if (load) begin
        grant_valid <= win_valid;
        grant <= win_valid ? win : '0;
        header <= win_valid ? src_header[win] : 24'h000000;
        sub <= win_valid ? src_sub[win] : '0;
      end
    end
  end
`ifdef PACKET_SCHEDULER_STATS_EN
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sent_count <= '0;
      null_count <= '0;
    end else begin
      if (ack_ev && sent_count != 16'hFFFF) sent_count <= sent_count + 16'd1;
      if (last && !grant_valid && null_count != 16'hFFFF) null_count <= null_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed self-checking bench for packet_scheduler with three sources
module tb_packet_scheduler;
  localparam int N = 3;
  logic clk_pixel = 1'b0;
  logic reset, data_island_period;
  logic [N-1:0] src_valid, src_ack;
  logic [N-1:0][23:0] src_header;
  logic [N-1:0][3:0][55:0] src_sub;
  logic [23:0] header;
  logic [3:0][55:0] sub;
  logic [4:0] slot_counter;
  logic [1:0] grant;
  logic grant_valid;
  int checks = 0, errors = 0;
`ifdef PACKET_SCHEDULER_STATS_EN
  logic [15:0] sent_count, null_count;
`endif

  packet_scheduler #(.NUM_SRC(N)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .data_island_period(data_island_period),
    .src_valid(src_valid), .src_header(src_header), .src_sub(src_sub), .src_ack(src_ack),
    .header(header), .sub(sub), .slot_counter(slot_counter), .grant(grant), .grant_valid(grant_valid)
`ifdef PACKET_SCHEDULER_STATS_EN
    , .sent_count(sent_count), .null_count(null_count)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    data_island_period = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [3:0][55:0] pattern(input int i);
    logic [3:0][55:0] p;
    for (int j = 0; j < 4; j++) p[j] = {7{8'(i * 16 + j + 1)}};
    return p;
  endfunction

  // Entered at slot_counter=0 with data_island_period high; leaves at slot_counter=0 of the next slot.
  task automatic run_slot(input string tag, input int g, input logic gv, input logic [N-1:0] ack);
    logic [23:0] eh;
    logic [3:0][55:0] es;
    eh = gv ? src_header[g] : 24'h0;
    es = gv ? src_sub[g] : '0;
    check({tag, " cnt0"}, 256'(slot_counter), 256'(0));
    check({tag, " grant"}, 256'(grant), 256'(g));
    check({tag, " gvalid"}, 256'(grant_valid), 256'(gv));
    check({tag, " header0"}, 256'(header), 256'(eh));
    check({tag, " sub0"}, 256'(sub), 256'(es));
    check({tag, " ack0"}, 256'(src_ack), 256'(0));
    repeat (16) tick();
    check({tag, " cnt16"}, 256'(slot_counter), 256'(16));
    check({tag, " header16"}, 256'(header), 256'(eh));
    check({tag, " ack16"}, 256'(src_ack), 256'(0));
    repeat (15) tick();
    check({tag, " cnt31"}, 256'(slot_counter), 256'(31));
    check({tag, " ack31"}, 256'(src_ack), 256'(ack));
    check({tag, " header31"}, 256'(header), 256'(eh));
    check({tag, " sub31"}, 256'(sub), 256'(es));
    tick();
  endtask

  initial begin
    src_header[0] = 24'h0A0B0C;
    src_header[1] = 24'h0D0282;
    src_header[2] = 24'h112233;
    for (int i = 0; i < N; i++) src_sub[i] = pattern(i);
    src_valid = '0;
    reset_dut();
    check("rst header", 256'(header), 256'(0));
    check("rst sub", 256'(sub), 256'(0));
    check("rst grant", 256'(grant), 256'(0));
    check("rst gvalid", 256'(grant_valid), 256'(0));
    check("rst ack", 256'(src_ack), 256'(0));
    check("rst cnt", 256'(slot_counter), 256'(0));
`ifdef PACKET_SCHEDULER_STATS_EN
    check("rst sent", 256'(sent_count), 256'(0));
    check("rst null", 256'(null_count), 256'(0));
`endif
    data_island_period = 1'b1;
    run_slot("idle s0", 0, 1'b0, 3'b000);
    run_slot("idle s1", 0, 1'b0, 3'b000);
    // single requester: still valid during its ack, next slot must be null
    reset_dut();
    src_valid = 3'b010;
    tick();
    check("single idle load", 256'(header), 256'(24'h0D0282));
    data_island_period = 1'b1;
    run_slot("single s0", 1, 1'b1, 3'b010);
    src_valid = '0;
    run_slot("single s1", 0, 1'b0, 3'b000);
    // round-robin with all sources always pending
    reset_dut();
    src_valid = 3'b111;
    tick();
    data_island_period = 1'b1;
    for (int s = 0; s < 6; s++) run_slot($sformatf("rr%0d", s), s % 3, 1'b1, N'(1) << (s % 3));
    // aborted slot
    reset_dut();
    src_valid = 3'b100;
    tick();
    data_island_period = 1'b1;
    repeat (17) tick();
    check("abort cnt17", 256'(slot_counter), 256'(17));
    data_island_period = 1'b0;
    check("abort ack", 256'(src_ack), 256'(0));
    repeat (3) tick();
    check("abort hold cnt", 256'(slot_counter), 256'(17));
    check("abort grant", 256'(grant), 256'(2));
    check("abort gvalid", 256'(grant_valid), 256'(1));
    check("abort idle ack", 256'(src_ack), 256'(0));
    reset_dut();
    tick();
    data_island_period = 1'b1;
    run_slot("abort regrant", 2, 1'b1, 3'b100);
    src_valid = '0;
    // idle load of src 0 then island
    reset_dut();
    src_valid = 3'b001;
    tick();
    data_island_period = 1'b1;
    run_slot("idle load", 0, 1'b1, 3'b001);
    // one persistent source alternates with null slots: 3 sent, 2 null
    reset_dut();
    src_valid = 3'b001;
    tick();
    data_island_period = 1'b1;
    run_slot("alt0", 0, 1'b1, 3'b001);
    run_slot("alt1", 0, 1'b0, 3'b000);
    run_slot("alt2", 0, 1'b1, 3'b001);
    run_slot("alt3", 0, 1'b0, 3'b000);
    run_slot("alt4", 0, 1'b1, 3'b001);
`ifdef PACKET_SCHEDULER_STATS_EN
    check("stats sent", 256'(sent_count), 256'(3));
    check("stats null", 256'(null_count), 256'(2));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
